// File: rtl/mcu_spi_responder.sv
// MCU link responder: deserialises 16-bit SPI command frames and hands them to the CPU side,
// acknowledging the MCU over a four-phase REQ/ACK handshake once the CPU has accepted.
module mcu_spi_responder #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RSTn,
  input  logic              MCU_SPI_SCLK,
  input  logic              MCU_SPI_CS,
  input  logic              MCU_SPI_MOSI,
  input  logic              MCU_REQ,
  output logic              MCU_ACK,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data,
  output logic              err_short,
  output logic              err_long,
  output logic              overrun
);

  localparam int unsigned FrameBits = 1 + ADDR_W + DATA_W;
  localparam int unsigned CntW      = $clog2(FrameBits + 2);
  localparam logic [CntW-1:0] FrameCnt = CntW'(FrameBits);
  localparam logic [CntW-1:0] SatCnt   = CntW'(FrameBits + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StPend  = 2'd2;
  localparam logic [1:0] StAck   = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, req_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s, req_s;
  logic                   sclk_rise, cs_rise, cs_fall;

  logic [1:0]             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [FrameBits-1:0]   sr_q, sr_d;
  logic                   wr_q, wr_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   err_short_q, err_short_d;
  logic                   err_long_q, err_long_d;
  logic                   overrun_q, overrun_d;

  // Synchronisers load the idle bus levels on reset so no false edge follows release.
  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RSTn) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      req_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], MCU_SPI_SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], MCU_SPI_CS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MCU_SPI_MOSI};
      req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], MCU_REQ};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign req_s     = req_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  assign cmd_valid = (state_q == StPend) & req_s;
  assign MCU_ACK   = (state_q == StAck);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    overrun_d   = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cs_rise) begin
          if (cnt_q == FrameCnt) begin
            {wr_d, addr_d, data_d} = sr_q;
            state_d                = StPend;
          end else begin
            err_short_d = (cnt_q < FrameCnt);
            err_long_d  = (cnt_q > FrameCnt);
            state_d     = StIdle;
          end
        end else if (sclk_rise && !cs_s) begin
          sr_d = {sr_q[FrameBits-2:0], mosi_s};
          if (cnt_q != SatCnt) cnt_d = cnt_q + 1'b1;
        end
      end
      StPend: begin
        if (cs_fall) overrun_d = 1'b1;
        if (cmd_valid && cmd_ready) state_d = StAck;
      end
      StAck: begin
        // A new window opening on the same cycle as REQ release goes straight to capture.
        if (!req_s) begin
          if (cs_fall) begin
            cnt_d   = '0;
            state_d = StShift;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RSTn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sr_q        <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cmd_wr    = wr_q;
  assign cmd_addr  = addr_q;
  assign cmd_data  = data_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mcu_spi_responder.sv
// Directed bench for mcu_spi_responder: SPI frames plus REQ/ACK handshakes, checked with
// immediate assertions against hand-computed values.
module tb_mcu_spi_responder;

  logic       SYS_CLK = 1'b0;
  logic       SYS_RSTn = 1'b0;
  logic       MCU_SPI_SCLK = 1'b0;
  logic       MCU_SPI_CS = 1'b1;
  logic       MCU_SPI_MOSI = 1'b0;
  logic       MCU_REQ = 1'b0;
  logic       MCU_ACK;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic       cmd_wr;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       err_short;
  logic       err_long;
  logic       overrun;

  int tests = 0;
  int errors = 0;
  int vcnt = 0, acnt = 0, es_cnt = 0, el_cnt = 0;

  mcu_spi_responder #(
    .ADDR_W      (7),
    .DATA_W      (8),
    .SYNC_STAGES (2)
  ) dut (
    .SYS_CLK      (SYS_CLK),
    .SYS_RSTn     (SYS_RSTn),
    .MCU_SPI_SCLK (MCU_SPI_SCLK),
    .MCU_SPI_CS   (MCU_SPI_CS),
    .MCU_SPI_MOSI (MCU_SPI_MOSI),
    .MCU_REQ      (MCU_REQ),
    .MCU_ACK      (MCU_ACK),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wr       (cmd_wr),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .err_short    (err_short),
    .err_long     (err_long),
    .overrun      (overrun)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  // Event counters sampled mid-cycle; only this process writes them.
  always @(negedge SYS_CLK) begin
    if (cmd_valid) vcnt++;
    if (MCU_ACK) acnt++;
    if (err_short) es_cnt++;
    if (err_long) el_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SCLK period is 100 ns (10 system clocks); MOSI changes while SCLK is low.
  task automatic send(input logic [31:0] v, input int n);
    @(negedge SYS_CLK);
    MCU_SPI_CS = 1'b0;
    #100;
    for (int i = n - 1; i >= 0; i--) begin
      MCU_SPI_MOSI = v[i];
      #50 MCU_SPI_SCLK = 1'b1;
      #50 MCU_SPI_SCLK = 1'b0;
    end
    MCU_SPI_MOSI = 1'b0;
    #50 MCU_SPI_CS = 1'b1;
    #100;
  endtask

  task automatic wait_for(input int sel, input logic lvl, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge SYS_CLK);
      if (((sel == 0) ? cmd_valid : MCU_ACK) === lvl) ok = 1'b1;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic accept(input logic w, input logic [6:0] a, input logic [7:0] d, input string tag);
    cmd_ready = 1'b1;
    MCU_REQ   = 1'b1;
    wait_for(0, 1'b1, {tag, " valid wait"});
    check({tag, " fields"}, {cmd_wr, cmd_addr, cmd_data}, {w, a, d});
    wait_for(1, 1'b1, {tag, " ack rise"});
    MCU_REQ = 1'b0;
    wait_for(1, 1'b0, {tag, " ack fall"});
    cmd_ready = 1'b0;
  endtask

  initial begin
    int vb, ab, eb, lb, hold_bad;

    repeat (4) @(negedge SYS_CLK);
    check("reset outputs",
          {MCU_ACK, cmd_valid, cmd_wr, cmd_addr, cmd_data, err_short, err_long, overrun}, 32'd0);
    SYS_RSTn = 1'b1;
    repeat (4) @(negedge SYS_CLK);

    // Nominal write 0x853C
    send(32'h853C, 16);
    check("nominal held, REQ low", {cmd_valid, MCU_ACK}, 32'd0);
    check("nominal fields", {cmd_wr, cmd_addr, cmd_data}, {1'b1, 7'h05, 8'h3C});
    vb = vcnt;
    cmd_ready = 1'b1;
    MCU_REQ   = 1'b1;
    wait_for(1, 1'b1, "nominal ack rise");
    check("nominal valid cycles", 32'(vcnt - vb), 32'd1);
    repeat (5) @(negedge SYS_CLK);
    check("nominal ack held", 32'(MCU_ACK), 32'd1);
    MCU_REQ = 1'b0;
    repeat (2) @(negedge SYS_CLK);
    check("ack before sync fall seen", 32'(MCU_ACK), 32'd1);
    @(negedge SYS_CLK);
    check("ack after sync fall", 32'(MCU_ACK), 32'd0);
    check("fields kept after accept", {cmd_wr, cmd_addr, cmd_data}, {1'b1, 7'h05, 8'h3C});
    cmd_ready = 1'b0;

    // Backpressure: 20 cycles of cmd_ready=0, then accept
    send(32'h853C, 16);
    vb = vcnt;
    MCU_REQ = 1'b1;
    wait_for(0, 1'b1, "bp valid wait");
    hold_bad = 0;
    repeat (20) begin
      @(negedge SYS_CLK);
      if (!(cmd_valid && !MCU_ACK && cmd_wr && cmd_addr == 7'h05 && cmd_data == 8'h3C))
        hold_bad++;
    end
    cmd_ready = 1'b1;
    wait_for(1, 1'b1, "bp ack rise");
    check("bp hold violations", 32'(hold_bad), 32'd0);
    check("bp valid cycles", 32'(vcnt - vb), 32'd21);
    MCU_REQ = 1'b0;
    wait_for(1, 1'b0, "bp ack fall");
    cmd_ready = 1'b0;

    // Short frame: 12 bits
    eb = es_cnt; lb = el_cnt; vb = vcnt; ab = acnt;
    send(32'h0ABC, 12);
    check("short err_short pulses", 32'(es_cnt - eb), 32'd1);
    check("short err_long pulses", 32'(el_cnt - lb), 32'd0);
    cmd_ready = 1'b1;
    MCU_REQ   = 1'b1;
    repeat (20) @(negedge SYS_CLK);
    MCU_REQ   = 1'b0;
    cmd_ready = 1'b0;
    repeat (5) @(negedge SYS_CLK);
    check("short no valid/ack", {16'(vcnt - vb), 16'(acnt - ab)}, 32'd0);

    // Long frame: 17 bits, then a good frame
    eb = es_cnt; lb = el_cnt; vb = vcnt;
    send(32'h1FFFF, 17);
    check("long err_long pulses", 32'(el_cnt - lb), 32'd1);
    check("long err_short pulses", 32'(es_cnt - eb), 32'd0);
    check("long no valid", 32'(vcnt - vb), 32'd0);
    send(32'h1234, 16);
    accept(1'b0, 7'h12, 8'h34, "after long");

    // Overrun: A pending, B dropped
    send(32'h0211, 16);
    check("overrun clear before B", 32'(overrun), 32'd0);
    send(32'h8FFF, 16);
    check("overrun set", 32'(overrun), 32'd1);
    check("overrun fields kept", {cmd_wr, cmd_addr, cmd_data}, {1'b0, 7'h02, 8'h11});
    accept(1'b0, 7'h02, 8'h11, "overrun accept");
    check("overrun sticky", 32'(overrun), 32'd1);

    // Spurious REQ in IDLE
    vb = vcnt; ab = acnt;
    MCU_REQ = 1'b1;
    repeat (50) @(negedge SYS_CLK);
    MCU_REQ = 1'b0;
    repeat (5) @(negedge SYS_CLK);
    check("spurious req ack cycles", 32'(acnt - ab), 32'd0);
    check("spurious req valid cycles", 32'(vcnt - vb), 32'd0);

    // Reset after 9 bits of a frame
    @(negedge SYS_CLK);
    MCU_SPI_CS = 1'b0;
    #100;
    for (int i = 8; i >= 0; i--) begin
      MCU_SPI_MOSI = 1'b1;
      #50 MCU_SPI_SCLK = 1'b1;
      #50 MCU_SPI_SCLK = 1'b0;
    end
    SYS_RSTn = 1'b0;
    repeat (3) @(negedge SYS_CLK);
    check("mid-frame reset outputs",
          {MCU_ACK, cmd_valid, cmd_wr, cmd_addr, cmd_data, err_short, err_long, overrun}, 32'd0);
    SYS_RSTn     = 1'b1;
    MCU_SPI_MOSI = 1'b0;
    MCU_SPI_CS   = 1'b1;
    repeat (10) @(negedge SYS_CLK);
    check("post reset outputs",
          {MCU_ACK, cmd_valid, cmd_wr, cmd_addr, cmd_data, err_short, err_long, overrun}, 32'd0);
    send(32'h8155, 16);
    accept(1'b1, 7'h01, 8'h55, "after reset");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
